// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle RV32I(+M) control unit. Each instruction is sequenced through
//   FETCH -> DECODE -> EXEC -> [MEM | MULDIV] -> WB, stalling on the
//   instruction-memory, data-memory and MDU handshakes. A watchdog traps a
//   stalled bus. An illegal encoding or a bus timeout parks the FSM in TRAP
//   until reset. Retirements are counted.
//
// Parameters
//   EN_M     1 = decode RV32M to MULDIV, 0 = RV32M encodings are illegal
//   TIMEOUT  max cycles waiting in FETCH or MEM before a bus-error trap (2..255)
//   CNT_W    width of the retired-instruction counter
//
// Ports
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_instr, i_instr_vld       instruction word (held by the IR) and fetch valid
//   i_mem_ack, i_md_done       data-memory complete, MDU result ready
//   i_br_less, i_br_equal      branch comparator results
//   o_if_req, o_ir_wren        fetch request, IR load
//   o_pc_wren, o_pc_sel        PC update, 0 = PC+4 / 1 = ALU target
//   o_br_un                    unsigned branch compare
//   o_rd_wren                  register-file write
//   o_mem_req, o_mem_wren      data-memory request, store
//   o_opa_sel, o_opb_sel       ALU A: rs1/PC, ALU B: rs2/imm
//   o_alu_op, o_wb_sel         ALU operation, writeback source
//   o_md_start                 one-cycle MDU start pulse
//   o_insn_vld                 one-cycle retire pulse
//   o_illegal, o_bus_err       sticky trap causes
//   o_state                    current FSM state
//   o_retire_cnt               retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter bit EN_M    = 1'b1,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instr,
  input  logic             i_instr_vld,
  input  logic             i_mem_ack,
  input  logic             i_md_done,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_if_req,
  output logic             o_ir_wren,
  output logic             o_pc_wren,
  output logic             o_pc_sel,
  output logic             o_br_un,
  output logic             o_rd_wren,
  output logic             o_mem_req,
  output logic             o_mem_wren,
  output logic             o_opa_sel,
  output logic             o_opb_sel,
  output logic [3:0]       o_alu_op,
  output logic [1:0]       o_wb_sel,
  output logic             o_md_start,
  output logic             o_insn_vld,
  output logic             o_illegal,
  output logic             o_bus_err,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_MULDIV = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_MDU  = 2'b11;

  // Watchdog value seen during the TIMEOUT-th waiting cycle.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [7:0]       wdog;
  logic             md_started;
  logic             set_illegal, set_bus_err;
  logic             dp_en;
  logic [CNT_W-1:0] retire_cnt;
  logic             illegal_q, bus_err_q;

  // ---------------------------------------------------------------------------
  // Instruction field decode (IR contents are stable from DECODE onwards)
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_r, is_i, is_load, is_store, is_br;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_m;
  logic       dec_illegal;
  logic       br_taken;
  logic       unused_instr_bits;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign unused_instr_bits = ^{i_instr[24:15], i_instr[11:7]};

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_m     = is_r && (funct7 == 7'b0000001);

  assign dec_illegal =
      !(is_r || is_i || is_load || is_store || is_br ||
        is_lui || is_auipc || is_jal || is_jalr)
      || (is_br && (funct3 == 3'b010 || funct3 == 3'b011))
      || (is_m && !EN_M);

  // funct3[2] selects the ordered compares; funct3[1] the unsigned forms,
  // which reuse the comparator's less-than under o_br_un.
  always_comb begin
    case (funct3)
      3'b000:  br_taken = i_br_equal;
      3'b001:  br_taken = !i_br_equal;
      3'b100,
      3'b110:  br_taken = i_br_less;
      3'b101,
      3'b111:  br_taken = !i_br_less;
      default: br_taken = 1'b0;
    endcase
  end

  // SUB is only reachable from R-type; SRA/SRAI both use funct7[5].
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                input logic       alt,
                                                input logic       reg_form);
    case (f3)
      3'b000:  return (alt && reg_form) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Datapath selects per instruction class; gated by dp_en below.
  logic       dec_opa, dec_opb, dec_br_un;
  logic [3:0] dec_alu;
  logic [1:0] dec_wb;

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_opa   = 1'b0;
    dec_opb   = 1'b0;
    dec_br_un = 1'b0;
    dec_alu   = ALU_ADD;
    dec_wb    = WB_ALU;
    case (opcode)
      OP_R: begin
        dec_alu = alu_from_funct(funct3, funct7[5], 1'b1);
        if (is_m) dec_wb = WB_MDU;
      end
      OP_I: begin
        dec_opb = 1'b1;
        dec_alu = alu_from_funct(funct3, funct7[5], 1'b0);
      end
      OP_LOAD: begin
        dec_opb = 1'b1;
        dec_wb  = WB_LOAD;
      end
      OP_STORE: dec_opb = 1'b1;
      OP_BR: begin
        dec_opa   = 1'b1;
        dec_opb   = 1'b1;
        dec_br_un = funct3[1];
      end
      OP_LUI: begin
        dec_opb = 1'b1;
        dec_alu = ALU_LUI;
      end
      OP_AUIPC: begin
        dec_opa = 1'b1;
        dec_opb = 1'b1;
      end
      OP_JAL: begin
        dec_opa = 1'b1;
        dec_opb = 1'b1;
        dec_wb  = WB_PC4;
      end
      OP_JALR: begin
        dec_opb = 1'b1;
        dec_wb  = WB_PC4;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and strobe logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    dp_en       = 1'b0;
    o_if_req    = 1'b0;
    o_ir_wren   = 1'b0;
    o_pc_wren   = 1'b0;
    o_pc_sel    = 1'b0;
    o_br_un     = 1'b0;
    o_rd_wren   = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_wren  = 1'b0;
    o_opa_sel   = 1'b0;
    o_opb_sel   = 1'b0;
    o_alu_op    = 4'b0000;
    o_wb_sel    = 2'b00;
    o_md_start  = 1'b0;
    o_insn_vld  = 1'b0;

    if (!i_reset) begin
      case (state)
        S_FETCH: begin
          o_if_req = 1'b1;
          if (i_instr_vld) begin
            o_ir_wren = 1'b1;
            state_nxt = S_DECODE;
          end else if (wdog == WDOG_LAST) begin
            set_bus_err = 1'b1;
            state_nxt   = S_TRAP;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            set_illegal = 1'b1;
            state_nxt   = S_TRAP;
          end else if (is_m) begin
            state_nxt = S_MULDIV;
          end else begin
            state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          dp_en = 1'b1;
          if (is_br) begin
            o_pc_sel   = br_taken;
            o_pc_wren  = 1'b1;
            o_insn_vld = 1'b1;
            state_nxt  = S_FETCH;
          end else if (is_jal || is_jalr) begin
            o_pc_sel   = 1'b1;
            o_rd_wren  = 1'b1;
            o_pc_wren  = 1'b1;
            o_insn_vld = 1'b1;
            state_nxt  = S_FETCH;
          end else if (is_load || is_store) begin
            state_nxt = S_MEM;
          end else begin
            state_nxt = S_WB;
          end
        end
        S_MEM: begin
          dp_en      = 1'b1;
          o_mem_req  = 1'b1;
          o_mem_wren = is_store;
          if (i_mem_ack) begin
            if (is_store) begin
              o_pc_wren  = 1'b1;
              o_insn_vld = 1'b1;
              state_nxt  = S_FETCH;
            end else begin
              state_nxt = S_WB;
            end
          end else if (wdog == WDOG_LAST) begin
            set_bus_err = 1'b1;
            state_nxt   = S_TRAP;
          end
        end
        S_MULDIV: begin
          dp_en      = 1'b1;
          o_md_start = !md_started;
          if (i_md_done) state_nxt = S_WB;
        end
        S_WB: begin
          dp_en      = 1'b1;
          o_rd_wren  = 1'b1;
          o_pc_wren  = 1'b1;
          o_insn_vld = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_TRAP:  state_nxt = S_TRAP;
        default: state_nxt = S_TRAP;
      endcase

      if (dp_en) begin
        o_opa_sel = dec_opa;
        o_opb_sel = dec_opb;
        o_br_un   = dec_br_un;
        o_alu_op  = dec_alu;
        o_wb_sel  = dec_wb;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, watchdog, counters and sticky flags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_FETCH;
      wdog       <= 8'd0;
      md_started <= 1'b0;
      retire_cnt <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Any state change restarts the watchdog, which covers every entry
      // into FETCH or MEM; it only advances while waiting in those states.
      if (state_nxt != state)
        wdog <= 8'd0;
      else if (state == S_FETCH || state == S_MEM)
        wdog <= wdog + 8'd1;
      md_started <= (state == S_MULDIV) && (state_nxt == S_MULDIV);
      if (o_insn_vld) retire_cnt <= retire_cnt + CNT_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  assign o_state      = i_reset ? S_FETCH : state;
  assign o_retire_cnt = retire_cnt;
  assign o_illegal    = illegal_q;
  assign o_bus_err    = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Three instances share one stimulus:
//   dut (EN_M=1, CNT_W=32), dut_nm (EN_M=0) and dut_c4 (CNT_W=4).
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BLTU = 32'h0020E463;
  localparam logic [31:0] I_JAL  = 32'h0080006F;
  localparam logic [31:0] I_MUL  = 32'h022081B3;

  logic        clk;
  logic        i_reset;
  logic [31:0] instr;
  logic        vld, ack, done, less, equal;

  // main instance
  logic       if_req, ir_wren, pc_wren, pc_sel, br_un, rd_wren, mem_req, mem_wren;
  logic       opa_sel, opb_sel, md_start, insn_vld, illegal, bus_err;
  logic [3:0] alu_op;
  logic [1:0] wb_sel;
  logic [2:0] state;
  logic [31:0] cnt;

  // EN_M = 0 instance
  logic       n_if_req, n_ir_wren, n_pc_wren, n_pc_sel, n_br_un, n_rd_wren, n_mem_req, n_mem_wren;
  logic       n_opa_sel, n_opb_sel, n_md_start, n_insn_vld, n_illegal, n_bus_err;
  logic [3:0] n_alu_op;
  logic [1:0] n_wb_sel;
  logic [2:0] n_state;
  logic [31:0] n_cnt;

  // CNT_W = 4 instance
  logic       c_if_req, c_ir_wren, c_pc_wren, c_pc_sel, c_br_un, c_rd_wren, c_mem_req, c_mem_wren;
  logic       c_opa_sel, c_opb_sel, c_md_start, c_insn_vld, c_illegal, c_bus_err;
  logic [3:0] c_alu_op;
  logic [1:0] c_wb_sel;
  logic [2:0] c_state;
  logic [3:0] c_cnt;

  int vectors;
  int miscompares;

  multicycle_ctrl #(.EN_M(1'b1), .TIMEOUT(16), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_instr(instr), .i_instr_vld(vld),
    .i_mem_ack(ack), .i_md_done(done), .i_br_less(less), .i_br_equal(equal),
    .o_if_req(if_req), .o_ir_wren(ir_wren), .o_pc_wren(pc_wren), .o_pc_sel(pc_sel),
    .o_br_un(br_un), .o_rd_wren(rd_wren), .o_mem_req(mem_req), .o_mem_wren(mem_wren),
    .o_opa_sel(opa_sel), .o_opb_sel(opb_sel), .o_alu_op(alu_op), .o_wb_sel(wb_sel),
    .o_md_start(md_start), .o_insn_vld(insn_vld), .o_illegal(illegal),
    .o_bus_err(bus_err), .o_state(state), .o_retire_cnt(cnt)
  );

  multicycle_ctrl #(.EN_M(1'b0), .TIMEOUT(16), .CNT_W(32)) dut_nm (
    .i_clk(clk), .i_reset(i_reset), .i_instr(instr), .i_instr_vld(vld),
    .i_mem_ack(ack), .i_md_done(done), .i_br_less(less), .i_br_equal(equal),
    .o_if_req(n_if_req), .o_ir_wren(n_ir_wren), .o_pc_wren(n_pc_wren), .o_pc_sel(n_pc_sel),
    .o_br_un(n_br_un), .o_rd_wren(n_rd_wren), .o_mem_req(n_mem_req), .o_mem_wren(n_mem_wren),
    .o_opa_sel(n_opa_sel), .o_opb_sel(n_opb_sel), .o_alu_op(n_alu_op), .o_wb_sel(n_wb_sel),
    .o_md_start(n_md_start), .o_insn_vld(n_insn_vld), .o_illegal(n_illegal),
    .o_bus_err(n_bus_err), .o_state(n_state), .o_retire_cnt(n_cnt)
  );

  multicycle_ctrl #(.EN_M(1'b1), .TIMEOUT(16), .CNT_W(4)) dut_c4 (
    .i_clk(clk), .i_reset(i_reset), .i_instr(instr), .i_instr_vld(vld),
    .i_mem_ack(ack), .i_md_done(done), .i_br_less(less), .i_br_equal(equal),
    .o_if_req(c_if_req), .o_ir_wren(c_ir_wren), .o_pc_wren(c_pc_wren), .o_pc_sel(c_pc_sel),
    .o_br_un(c_br_un), .o_rd_wren(c_rd_wren), .o_mem_req(c_mem_req), .o_mem_wren(c_mem_wren),
    .o_opa_sel(c_opa_sel), .o_opb_sel(c_opb_sel), .o_alu_op(c_alu_op), .o_wb_sel(c_wb_sel),
    .o_md_start(c_md_start), .o_insn_vld(c_insn_vld), .o_illegal(c_illegal),
    .o_bus_err(c_bus_err), .o_state(c_state), .o_retire_cnt(c_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: run did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // From a FETCH cycle: present an instruction with valid, land in DECODE.
  task automatic fetch(input logic [31:0] ins);
    instr = ins;
    vld   = 1'b1;
    #1;
    check("fetch_if_req", {31'd0, if_req}, 32'd1);
    check("fetch_ir_wren", {31'd0, ir_wren}, 32'd1);
    cyc();
    vld = 1'b0;
    #1;
    check("decode_state", {29'd0, state}, 32'd1);
    check("decode_opb_gated", {31'd0, opb_sel}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_reset = 1'b1;
    instr   = 32'd0;
    vld = 1'b0; ack = 1'b0; done = 1'b0; less = 1'b0; equal = 1'b0;

    // ---- reset ----
    cyc();
    check("rst_if_req", {31'd0, if_req}, 32'd0);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_pc_wren", {31'd0, pc_wren}, 32'd0);
    i_reset = 1'b0;
    #1;
    check("post_rst_state", {29'd0, state}, 32'd0);
    check("post_rst_if_req", {31'd0, if_req}, 32'd1);
    check("post_rst_cnt", cnt, 32'd0);
    check("post_rst_illegal", {31'd0, illegal}, 32'd0);
    check("post_rst_bus_err", {31'd0, bus_err}, 32'd0);

    // ---- ADD: FETCH, DECODE, EXEC, WB ----
    fetch(I_ADD);
    cyc(); #1;
    check("add_exec_state", {29'd0, state}, 32'd2);
    check("add_exec_alu", {28'd0, alu_op}, 32'd0);
    check("add_exec_pc_wren", {31'd0, pc_wren}, 32'd0);
    check("add_exec_insn_vld", {31'd0, insn_vld}, 32'd0);
    cyc(); #1;
    check("add_wb_state", {29'd0, state}, 32'd5);
    check("add_wb_rd_wren", {31'd0, rd_wren}, 32'd1);
    check("add_wb_pc_wren", {31'd0, pc_wren}, 32'd1);
    check("add_wb_pc_sel", {31'd0, pc_sel}, 32'd0);
    check("add_wb_insn_vld", {31'd0, insn_vld}, 32'd1);
    check("add_wb_wb_sel", {30'd0, wb_sel}, 32'd0);
    cyc(); #1;
    check("add_fetch_state", {29'd0, state}, 32'd0);
    check("add_cnt", cnt, 32'd1);

    // ---- LW: ack in the third MEM cycle ----
    fetch(I_LW);
    cyc(); #1;
    check("lw_exec_opb", {31'd0, opb_sel}, 32'd1);
    check("lw_exec_mem_req", {31'd0, mem_req}, 32'd0);
    cyc(); #1;
    check("lw_mem1_req", {31'd0, mem_req}, 32'd1);
    check("lw_mem1_wren", {31'd0, mem_wren}, 32'd0);
    check("lw_mem1_wb_sel", {30'd0, wb_sel}, 32'd1);
    cyc(); #1;
    check("lw_mem2_req", {31'd0, mem_req}, 32'd1);
    cyc();
    ack = 1'b1;
    #1;
    check("lw_mem3_req", {31'd0, mem_req}, 32'd1);
    check("lw_mem3_insn_vld", {31'd0, insn_vld}, 32'd0);
    cyc();
    ack = 1'b0;
    #1;
    check("lw_wb_state", {29'd0, state}, 32'd5);
    check("lw_wb_wb_sel", {30'd0, wb_sel}, 32'd1);
    check("lw_wb_rd_wren", {31'd0, rd_wren}, 32'd1);
    check("lw_wb_mem_req", {31'd0, mem_req}, 32'd0);
    cyc(); #1;
    check("lw_cnt", cnt, 32'd2);

    // ---- SW: ack in the first MEM cycle retires there ----
    fetch(I_SW);
    cyc(); cyc();
    ack = 1'b1;
    #1;
    check("sw_mem_state", {29'd0, state}, 32'd3);
    check("sw_mem_wren", {31'd0, mem_wren}, 32'd1);
    check("sw_mem_pc_wren", {31'd0, pc_wren}, 32'd1);
    check("sw_mem_insn_vld", {31'd0, insn_vld}, 32'd1);
    check("sw_mem_rd_wren", {31'd0, rd_wren}, 32'd0);
    cyc();
    ack = 1'b0;
    #1;
    check("sw_fetch_state", {29'd0, state}, 32'd0);
    check("sw_cnt", cnt, 32'd3);

    // ---- BEQ taken ----
    fetch(I_BEQ);
    cyc();
    equal = 1'b1;
    #1;
    check("beq_t_pc_sel", {31'd0, pc_sel}, 32'd1);
    check("beq_t_pc_wren", {31'd0, pc_wren}, 32'd1);
    check("beq_t_insn_vld", {31'd0, insn_vld}, 32'd1);
    check("beq_t_br_un", {31'd0, br_un}, 32'd0);
    check("beq_t_opa", {31'd0, opa_sel}, 32'd1);
    cyc();
    equal = 1'b0;
    #1;
    check("beq_t_fetch", {29'd0, state}, 32'd0);
    check("beq_t_cnt", cnt, 32'd4);

    // ---- BEQ not taken ----
    fetch(I_BEQ);
    cyc(); #1;
    check("beq_nt_pc_sel", {31'd0, pc_sel}, 32'd0);
    check("beq_nt_pc_wren", {31'd0, pc_wren}, 32'd1);
    cyc(); #1;
    check("beq_nt_cnt", cnt, 32'd5);

    // ---- BLTU taken (unsigned) ----
    fetch(I_BLTU);
    cyc();
    less = 1'b1;
    #1;
    check("bltu_br_un", {31'd0, br_un}, 32'd1);
    check("bltu_pc_sel", {31'd0, pc_sel}, 32'd1);
    cyc();
    less = 1'b0;
    #1;
    check("bltu_cnt", cnt, 32'd6);

    // ---- JAL ----
    fetch(I_JAL);
    cyc(); #1;
    check("jal_pc_sel", {31'd0, pc_sel}, 32'd1);
    check("jal_rd_wren", {31'd0, rd_wren}, 32'd1);
    check("jal_wb_sel", {30'd0, wb_sel}, 32'd2);
    check("jal_insn_vld", {31'd0, insn_vld}, 32'd1);
    cyc(); #1;
    check("jal_cnt", cnt, 32'd7);

    // ---- MUL: EN_M=1 runs MULDIV, EN_M=0 traps ----
    fetch(I_MUL);
    cyc(); #1;
    check("mul_md1_state", {29'd0, state}, 32'd4);
    check("mul_md1_start", {31'd0, md_start}, 32'd1);
    check("mul_md1_wb_sel", {30'd0, wb_sel}, 32'd3);
    check("nm_trap_state", {29'd0, n_state}, 32'd6);
    check("nm_illegal", {31'd0, n_illegal}, 32'd1);
    check("nm_trap_if_req", {31'd0, n_if_req}, 32'd0);
    for (int k = 2; k <= 4; k++) begin
      cyc(); #1;
      check("mul_md_wait_state", {29'd0, state}, 32'd4);
      check("mul_md_wait_start", {31'd0, md_start}, 32'd0);
    end
    cyc();
    done = 1'b1;
    #1;
    check("mul_md5_start", {31'd0, md_start}, 32'd0);
    cyc();
    done = 1'b0;
    #1;
    check("mul_wb_state", {29'd0, state}, 32'd5);
    check("mul_wb_wb_sel", {30'd0, wb_sel}, 32'd3);
    check("mul_wb_rd_wren", {31'd0, rd_wren}, 32'd1);
    cyc(); #1;
    check("mul_cnt", cnt, 32'd8);
    check("c4_cnt_mid", {28'd0, c_cnt}, 32'd8);

    // ---- LW with no ack: watchdog trap after 16 MEM cycles ----
    fetch(I_LW);
    cyc(); cyc();
    for (int k = 1; k <= 16; k++) begin
      #1;
      check("to_mem_state", {29'd0, state}, 32'd3);
      cyc();
    end
    #1;
    check("to_trap_state", {29'd0, state}, 32'd6);
    check("to_bus_err", {31'd0, bus_err}, 32'd1);
    check("to_illegal", {31'd0, illegal}, 32'd0);
    check("to_mem_req", {31'd0, mem_req}, 32'd0);
    ack = 1'b1;
    cyc(); #1;
    check("to_trap_hold", {29'd0, state}, 32'd6);
    check("to_cnt_hold", cnt, 32'd8);
    ack = 1'b0;

    // ---- reset out of TRAP ----
    i_reset = 1'b1;
    #1;
    check("trap_rst_state_out", {29'd0, state}, 32'd0);
    check("trap_rst_if_req", {31'd0, if_req}, 32'd0);
    cyc();
    i_reset = 1'b0;
    #1;
    check("trap_rst_fetch", {29'd0, state}, 32'd0);
    check("trap_rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("trap_rst_cnt", cnt, 32'd0);
    check("trap_rst_nm_illegal", {31'd0, n_illegal}, 32'd0);

    // ---- vld in the 16th FETCH cycle and ack in the 16th MEM cycle ----
    for (int k = 1; k <= 15; k++) begin
      check("late_fetch_state", {29'd0, state}, 32'd0);
      cyc(); #1;
    end
    fetch(I_LW);
    cyc(); cyc();
    for (int k = 1; k <= 15; k++) begin
      #1;
      check("late_mem_state", {29'd0, state}, 32'd3);
      cyc();
    end
    ack = 1'b1;
    #1;
    check("late_mem16_req", {31'd0, mem_req}, 32'd1);
    cyc();
    ack = 1'b0;
    #1;
    check("late_wb_state", {29'd0, state}, 32'd5);
    check("late_bus_err", {31'd0, bus_err}, 32'd0);
    cyc(); #1;
    check("late_cnt", cnt, 32'd1);

    // ---- all-zero instruction is illegal ----
    fetch(32'h00000000);
    cyc(); #1;
    check("zero_state", {29'd0, state}, 32'd6);
    check("zero_illegal", {31'd0, illegal}, 32'd1);
    check("zero_bus_err", {31'd0, bus_err}, 32'd0);
    check("zero_cnt", cnt, 32'd1);

    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
    #1;
    check("rst2_illegal", {31'd0, illegal}, 32'd0);
    check("rst2_c4_cnt", {28'd0, c_cnt}, 32'd0);

    // ---- 16 back-to-back retirements: 4-bit counter wraps 15 -> 0 ----
    for (int k = 0; k < 16; k++) begin
      fetch(I_ADD);
      cyc(); cyc(); cyc(); #1;
      check("wrap_c4_cnt", {28'd0, c_cnt}, 32'((k + 1) % 16));
      check("wrap_main_cnt", cnt, 32'(k + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle successor to the single-cycle RV32I control decoder. A state machine sequences each instruction through fetch, decode, execute, memory and writeback, and stalls on handshakes from instruction memory, data memory and an optional multiply/divide unit. It adds parametrised M-extension decode, a bus watchdog, a sticky trap state and a retired-instruction counter. It sits between the IF/LSU/MDU handshakes and the existing datapath (ALU, regfile, branch comparator, PC register).

Parameters:
EN_M, 0, 1 = decode RV32M (opcode 0110011, funct7 0000001) to MULDIV; 0 = treat those encodings as illegal
TIMEOUT, 16, maximum cycles spent waiting in FETCH or MEM before a bus-error trap (range 2..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_instr  in  32  instruction; valid with i_instr_vld, then held stable by the IR until the next o_ir_wren
i_instr_vld  in  1  instruction-memory data valid
i_mem_ack  in  1  data-memory access complete
i_md_done  in  1  MDU result ready
i_br_less  in  1  branch comparator less-than
i_br_equal  in  1  branch comparator equal
o_if_req  out  1  instruction fetch request
o_ir_wren  out  1  latch i_instr into the IR
o_pc_wren  out  1  update PC
o_pc_sel  out  1  0 = PC+4, 1 = ALU target
o_br_un  out  1  unsigned compare
o_rd_wren  out  1  regfile write
o_mem_req  out  1  data-memory request
o_mem_wren  out  1  store
o_opa_sel  out  1  0 = rs1, 1 = PC
o_opb_sel  out  1  0 = rs2, 1 = imm
o_alu_op  out  4  same encoding as the single-cycle decoder (ADD 0000 … SRA 1001, LUI 1111)
o_wb_sel  out  2  00 = ALU, 01 = load, 10 = PC+4, 11 = MDU
o_md_start  out  1  one-cycle MDU start pulse
o_insn_vld  out  1  one-cycle retire pulse
o_illegal  out  1  sticky illegal-instruction flag
o_bus_err  out  1  sticky watchdog flag
o_state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, MULDIV 4, WB 5, TRAP 6
o_retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset (sync): state = FETCH, watchdog = 0, o_retire_cnt = 0, o_illegal = 0, o_bus_err = 0. While i_reset is high, all other outputs are 0. Reset overrides every state, including TRAP and mid-wait.
- All control outputs are decoded from state plus i_instr. Datapath selects (opa/opb/alu_op/br_un/wb_sel) are valid in EXEC, MEM, MULDIV and WB, and are 0 in FETCH, DECODE and TRAP.
- FETCH: o_if_req = 1. When i_instr_vld = 1: o_ir_wren = 1 for that cycle, then go to DECODE.
- DECODE: opcode not in {R, I-ALU, load, store, branch, LUI, AUIPC, JAL, JALR}, branch funct3 010/011, or M-encoding with EN_M = 0 → TRAP, set o_illegal. M-encoding with EN_M = 1 → MULDIV. Otherwise → EXEC.
- EXEC (one cycle):
  - Branch: o_pc_sel = taken per funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU, with br_un for the U forms), o_pc_wren = 1, o_insn_vld = 1, → FETCH.
  - JAL/JALR: o_pc_sel = 1, o_rd_wren = 1, o_wb_sel = 10, o_pc_wren = 1, o_insn_vld = 1, → FETCH.
  - Load/store: → MEM.
  - Others: → WB.
- MEM: o_mem_req = 1 and o_mem_wren = store, held until i_mem_ack.
  - On ack, load → WB.
  - On ack, store: o_pc_wren = 1, o_insn_vld = 1 in the ack cycle, → FETCH.
- MULDIV: o_md_start = 1 only in the first cycle. Wait for i_md_done, then → WB with o_wb_sel = 11.
- WB: o_rd_wren = 1, o_pc_wren = 1 (pc_sel = 0), o_insn_vld = 1, → FETCH.
- Watchdog: cleared on entry to FETCH/MEM, incremented each waiting cycle. If the count reaches TIMEOUT with no vld/ack → TRAP, set o_bus_err. A vld/ack arriving in the TIMEOUT-th cycle wins over the trap.
- TRAP: absorbing until reset. All strobes are 0; flags hold.
- o_retire_cnt increments on every o_insn_vld and wraps modulo 2^CNT_W.
- i_br_*, i_mem_ack and i_md_done are ignored outside their own states.

Test Plan:
- ADD 0x002081B3, i_instr_vld in the first cycle → states 0,1,2,5. alu_op = 0000 in EXEC/WB; rd_wren, pc_wren, insn_vld in cycle 4; o_retire_cnt = 1.
- LW 0x0000A183, i_mem_ack 3 cycles after MEM entry → mem_req high for 3 cycles, mem_wren = 0, then WB with wb_sel = 01. SW 0x0020A023 → mem_wren = 1, retire in the ack cycle, no rd_wren.
- BEQ 0x00208463: br_equal = 1 → pc_sel = 1, pc_wren in EXEC, 3 cycles. br_equal = 0 → pc_sel = 0. BLTU 0x0020E463 → br_un = 1.
- MUL 0x022081B3: EN_M = 1, md_done after 5 cycles → one md_start pulse, WB with wb_sel = 11. EN_M = 0 → TRAP, o_illegal = 1, o_state = 6.
- TIMEOUT = 16, i_mem_ack never asserted on LW → TRAP after 16 MEM cycles, o_bus_err = 1. Ack exactly in cycle 16 → no trap. i_reset in TRAP → FETCH, flags and counter cleared.
- i_instr = 0x00000000 → TRAP/illegal. Back-to-back 2^CNT_W retirements with CNT_W = 4 → counter wraps 15→0.
